// File: rtl/l1_trigger_decision.sv
// L1 trigger decision: persistence + deadtime on the neuron score y_in.
// Ports: clk, rst, y_in/y_valid, threshold, enable -> trig_out, trig_busy,
// trig_count (saturating), peak_out. Optional macro: TRIG_PRESCALE_EN.
module l1_trigger_decision #(
  parameter int DATA_W   = 16,
  parameter int PERSIST  = 2,
  parameter int DEADTIME = 8,
  parameter int CNT_W    = 16
`ifdef TRIG_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic                     y_valid,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  output logic                     trig_out,
  output logic                     trig_busy,
  output logic [CNT_W-1:0]         trig_count,
  output logic signed [DATA_W-1:0] peak_out
);

  localparam int RW = $clog2(PERSIST + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(PERSIST - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;

  logic [1:0]               state;
  logic [RW-1:0]            run_cnt;
  logic [DW-1:0]            dead_cnt;
  logic signed [DATA_W-1:0] peak_run;
  logic signed [DATA_W-1:0] peak_nxt;
  logic                     qual;
  logic                     fire;
  logic                     pulse;
  logic                     live;

  assign live = (state == S_IDLE) || (state == S_ARMED);
  assign qual = y_valid && enable && (y_in > threshold);

  // run_cnt is zero in IDLE, so one compare covers PERSIST=1 too
  assign fire = live && qual && (run_cnt == RUN_LAST);

  assign peak_nxt = (state == S_ARMED && peak_run > y_in)
                  ? peak_run : y_in;

`ifdef TRIG_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // first fire after reset pulses, then every PRESCALE-th
  assign pulse = (pre_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (fire) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end
  end
`else
  assign pulse = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      run_cnt    <= '0;
      dead_cnt   <= '0;
      peak_run   <= '0;
      trig_out   <= 1'b0;
      trig_busy  <= 1'b0;
      trig_count <= '0;
      peak_out   <= '0;
    end else begin
      trig_out <= 1'b0;
      if (fire) begin
        trig_out  <= pulse;
        trig_busy <= 1'b1;
        dead_cnt  <= DEAD_LAST;
        peak_out  <= peak_nxt;
        if (trig_count != '1)
          trig_count <= trig_count + CNT_W'(1);
        state    <= S_DEAD;
        run_cnt  <= '0;
        peak_run <= '0;
      end else begin
        case (state)
          S_IDLE, S_ARMED: begin
            if (qual) begin
              run_cnt  <= run_cnt + RW'(1);
              peak_run <= peak_nxt;
              state    <= S_ARMED;
            end else if (!enable || y_valid) begin
              // gaps (y_valid=0) keep the run alive
              run_cnt  <= '0;
              peak_run <= '0;
              state    <= S_IDLE;
            end
          end
          S_DEAD: begin
            if (dead_cnt == '0) begin
              trig_busy <= 1'b0;
              state     <= S_IDLE;
            end else begin
              dead_cnt <= dead_cnt - DW'(1);
            end
          end
          default: begin
            run_cnt   <= '0;
            peak_run  <= '0;
            trig_busy <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l1_trigger_decision.sv
// Directed bench for l1_trigger_decision.
// Main DUT plus a CNT_W=2 copy (saturation) and, with the macro, PRESCALE=4.
module tb_l1_trigger_decision;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] y_in = '0;
  logic y_valid = 1'b0;
  logic signed [15:0] threshold = 16'sd20;
  logic enable = 1'b1;

  logic trig_out, trig_busy;
  logic [15:0] trig_count;
  logic signed [15:0] peak_out;

  logic trig2, busy2;
  logic [1:0] cnt2;
  logic signed [15:0] peak2;

  int ncmp = 0;
  int nerr = 0;
  int np = 0;
  int p0;

  always #5 clk = ~clk;

  l1_trigger_decision #(
`ifdef TRIG_PRESCALE_EN
    .PRESCALE(1),
`endif
    .DATA_W(16), .PERSIST(2),
    .DEADTIME(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .y_in(y_in), .y_valid(y_valid),
    .threshold(threshold), .enable(enable),
    .trig_out(trig_out), .trig_busy(trig_busy),
    .trig_count(trig_count), .peak_out(peak_out)
  );

  l1_trigger_decision #(
`ifdef TRIG_PRESCALE_EN
    .PRESCALE(1),
`endif
    .DATA_W(16), .PERSIST(2),
    .DEADTIME(8), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .y_in(y_in), .y_valid(y_valid),
    .threshold(threshold), .enable(enable),
    .trig_out(trig2), .trig_busy(busy2),
    .trig_count(cnt2), .peak_out(peak2)
  );

`ifdef TRIG_PRESCALE_EN
  logic trig3, busy3;
  logic [15:0] cnt3;
  logic signed [15:0] peak3;
  int np3 = 0;
  int q0;

  l1_trigger_decision #(
    .PRESCALE(4),
    .DATA_W(16), .PERSIST(2),
    .DEADTIME(8), .CNT_W(16)
  ) dut3 (
    .clk(clk), .rst(rst),
    .y_in(y_in), .y_valid(y_valid),
    .threshold(threshold), .enable(enable),
    .trig_out(trig3), .trig_busy(busy3),
    .trig_count(cnt3), .peak_out(peak3)
  );

  always @(posedge clk) if (trig3) np3++;
`endif

  always @(posedge clk) if (trig_out) np++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [15:0] y);
    y_valid = v;
    y_in = y;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 16'd0);
  endtask

  task automatic zchk(input string tag);
    chk({tag, "_trig"}, 32'(trig_out), 0);
    chk({tag, "_busy"}, 32'(trig_busy), 0);
    chk({tag, "_cnt"}, 32'(trig_count), 0);
    chk({tag, "_peak"}, 32'(peak_out), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    zchk("rst");
    rst = 1'b0;

    drv(1'b1, 16'd35);
    chk("basic_early", 32'(trig_out), 0);
    drv(1'b1, 16'd35);
    chk("basic_trig", 32'(trig_out), 1);
    chk("basic_cnt", 32'(trig_count), 1);
    chk("basic_peak", 32'(peak_out), 35);
    chk("basic_busy1", 32'(trig_busy), 1);
    drv(1'b0, 16'd0);
    chk("basic_one", 32'(trig_out), 0);
    idle(6);
    chk("basic_busy8", 32'(trig_busy), 1);
    idle(1);
    chk("basic_busy_end", 32'(trig_busy), 0);

    p0 = np;
    drv(1'b1, 16'd0);
    drv(1'b1, 16'd0);
    drv(1'b1, 16'd20);
    drv(1'b1, 16'd20);
    idle(2);
    chk("reject_pulses", 32'(np - p0), 0);
    chk("reject_cnt", 32'(trig_count), 1);

    p0 = np;
    drv(1'b1, 16'd35);
    drv(1'b1, 16'd0);
    drv(1'b1, 16'd35);
    idle(2);
    chk("break_pulses", 32'(np - p0), 0);
    drv(1'b1, 16'd0);

    drv(1'b1, 16'd35);
    idle(3);
    drv(1'b1, 16'd35);
    chk("gap_trig", 32'(trig_out), 1);
    chk("gap_cnt", 32'(trig_count), 2);
    chk("gap_peak", 32'(peak_out), 35);
    idle(8);

    drv(1'b1, 16'd25);
    threshold = 16'sd50;
    drv(1'b1, 16'd90);
    chk("peak_trig", 32'(trig_out), 1);
    chk("peak_val", 32'(peak_out), 90);
    chk("peak_cnt", 32'(trig_count), 3);
    threshold = 16'sd20;
    idle(8);

    p0 = np;
    repeat (30) drv(1'b1, 16'd40);
    idle(2);
    chk("dead_pulses", 32'(np - p0), 3);
    chk("dead_cnt", 32'(trig_count), 6);

    drv(1'b1, 16'd40);
    y_valid = 1'b0;
    rst = 1'b1;
    #1;
    zchk("rst_armed");
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 16'd40);
    chk("rst_armed_fresh", 32'(trig_out), 0);
    drv(1'b1, 16'd40);
    chk("rst_armed_fire", 32'(trig_out), 1);
    chk("rst_armed_cnt", 32'(trig_count), 1);

    drv(1'b0, 16'd0);
    rst = 1'b1;
    #1;
    zchk("rst_dead");
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 16'd40);
    chk("rst_dead_fresh", 32'(trig_out), 0);
    drv(1'b1, 16'd40);
    chk("rst_dead_fire", 32'(trig_out), 1);
    chk("rst_dead_cnt", 32'(trig_count), 1);
    idle(8);

    repeat (4) begin
      drv(1'b1, 16'd40);
      drv(1'b1, 16'd40);
      idle(8);
    end
    chk("sat_main_cnt", 32'(trig_count), 5);
    chk("sat_cnt2", 32'(cnt2), 3);

    drv(1'b1, 16'd40);
    enable = 1'b0;
    drv(1'b1, 16'd40);
    chk("en_off", 32'(trig_out), 0);
    enable = 1'b1;
    drv(1'b1, 16'd40);
    chk("en_fresh", 32'(trig_out), 0);
    drv(1'b1, 16'd40);
    chk("en_fire", 32'(trig_out), 1);
    chk("en_cnt", 32'(trig_count), 6);
    idle(8);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0 = np;
`ifdef TRIG_PRESCALE_EN
    q0 = np3;
`endif
    repeat (8) begin
      drv(1'b1, 16'd40);
      drv(1'b1, 16'd40);
      idle(8);
    end
    chk("eight_pulses", 32'(np - p0), 8);
    chk("eight_cnt", 32'(trig_count), 8);
`ifdef TRIG_PRESCALE_EN
    chk("pre_pulses", 32'(np3 - q0), 2);
    chk("pre_cnt", 32'(cnt3), 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
